// File: rtl/cmd_frame_decoder.sv
// Command frame decoder: turns a stream of received bytes into
// register-file write/read strobes and ALU start strobes.
module cmd_frame_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_Data,
  input  logic                  RX_Valid,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Addr,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  Busy,
  output logic                  Cmd_Err,
  output logic                  Addr_Err
);

  localparam logic [DATA_WIDTH-1:0] C_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] C_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] C_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] C_OP  = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    ALU_A,
    ALU_B,
    ALU_OP
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            fun_q, fun_d;
  logic                  wren_q, wren_d;
  logic                  rden_q, rden_d;
  logic                  aluen_q, aluen_d;
  logic                  cerr_q, cerr_d;
  logic                  aerr_q, aerr_d;
  logic                  busy_q, busy_d;

  logic                  addr_bad;
  logic [ADDR_WIDTH-1:0] byte_addr;

  // An address byte is bad if any bit beyond the address field is set
  assign addr_bad  = |(RX_Data >> ADDR_WIDTH);
  assign byte_addr = RX_Data[ADDR_WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rf_addr_d = rf_addr_q;
    wdata_d   = wdata_q;
    fun_d     = fun_q;
    wren_d    = 1'b0;
    rden_d    = 1'b0;
    aluen_d   = 1'b0;
    cerr_d    = 1'b0;
    aerr_d    = 1'b0;
    if (RX_Valid) begin
      case (state_q)
        IDLE: begin
          case (RX_Data)
            C_WR:    state_d = WR_ADDR;
            C_RD:    state_d = RD_ADDR;
            C_ALU:   state_d = ALU_A;
            C_OP:    state_d = ALU_OP;
            default: cerr_d  = 1'b1;
          endcase
        end
        WR_ADDR: begin
          if (addr_bad) begin
            aerr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            wr_addr_d = byte_addr;
            state_d   = WR_DATA;
          end
        end
        WR_DATA: begin
          wren_d    = 1'b1;
          rf_addr_d = wr_addr_q;
          wdata_d   = RX_Data;
          state_d   = IDLE;
        end
        RD_ADDR: begin
          if (addr_bad) begin
            aerr_d = 1'b1;
          end else begin
            rden_d    = 1'b1;
            rf_addr_d = byte_addr;
          end
          state_d = IDLE;
        end
        ALU_A: begin
          wren_d    = 1'b1;
          rf_addr_d = '0;
          wdata_d   = RX_Data;
          state_d   = ALU_B;
        end
        ALU_B: begin
          wren_d    = 1'b1;
          rf_addr_d = ADDR_WIDTH'(1);
          wdata_d   = RX_Data;
          state_d   = ALU_OP;
        end
        ALU_OP: begin
          aluen_d = 1'b1;
          fun_d   = RX_Data[3:0];
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      rf_addr_q <= '0;
      wdata_q   <= '0;
      fun_q     <= '0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      aluen_q   <= 1'b0;
      cerr_q    <= 1'b0;
      aerr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rf_addr_q <= rf_addr_d;
      wdata_q   <= wdata_d;
      fun_q     <= fun_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
      aluen_q   <= aluen_d;
      cerr_q    <= cerr_d;
      aerr_q    <= aerr_d;
      busy_q    <= busy_d;
    end
  end

  assign RF_WrEn   = wren_q;
  assign RF_RdEn   = rden_q;
  assign RF_Addr   = rf_addr_q;
  assign RF_WrData = wdata_q;
  assign ALU_EN    = aluen_q;
  assign ALU_FUN   = fun_q;
  assign Busy      = busy_q;
  assign Cmd_Err   = cerr_q;
  assign Addr_Err  = aerr_q;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Bench for cmd_frame_decoder: frame-level reference model checked
// every cycle, plus directed frames with literal expectations.
module tb_cmd_frame_decoder;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] RX_Data = '0;
  logic          RX_Valid = 1'b0;
  logic          RF_WrEn, RF_RdEn, ALU_EN, Busy, Cmd_Err, Addr_Err;
  logic [AW-1:0] RF_Addr;
  logic [DW-1:0] RF_WrData;
  logic [3:0]    ALU_FUN;

  cmd_frame_decoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .RX_Data(RX_Data), .RX_Valid(RX_Valid),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Addr(RF_Addr),
    .RF_WrData(RF_WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .Busy(Busy), .Cmd_Err(Cmd_Err), .Addr_Err(Addr_Err)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: collect the bytes of the current frame, act when complete
  logic [7:0] fr[$];
  logic [7:0] m_a;
  logic       e_wr = 0, e_rd = 0, e_alu = 0, e_cerr = 0, e_aerr = 0;
  logic       e_busy = 0;
  logic [3:0] e_addr = 0, e_fun = 0;
  logic [7:0] e_wd = 0;

  always @(posedge CLK) begin
    e_wr = 0; e_rd = 0; e_alu = 0; e_cerr = 0; e_aerr = 0;
    if (RST) begin
      fr.delete();
      e_addr = 0; e_wd = 0; e_fun = 0;
    end else if (RX_Valid) begin
      fr.push_back(RX_Data);
      if (fr.size() == 1) begin
        if (!(fr[0] inside {8'hAA, 8'hBB, 8'hCC, 8'hDD})) begin
          e_cerr = 1;
          fr.delete();
        end
      end else begin
        m_a = fr[1];
        case (fr[0])
          8'hAA: begin
            if (fr.size() == 2) begin
              if ((m_a >> AW) != 0) begin
                e_aerr = 1;
                fr.delete();
              end
            end else begin
              e_wr = 1;
              e_addr = m_a[3:0];
              e_wd = RX_Data;
              fr.delete();
            end
          end
          8'hBB: begin
            if ((m_a >> AW) != 0) e_aerr = 1;
            else begin
              e_rd = 1;
              e_addr = m_a[3:0];
            end
            fr.delete();
          end
          8'hCC: begin
            if (fr.size() == 4) begin
              e_alu = 1;
              e_fun = RX_Data[3:0];
              fr.delete();
            end else begin
              e_wr = 1;
              e_addr = (fr.size() == 2) ? 4'd0 : 4'd1;
              e_wd = RX_Data;
            end
          end
          default: begin
            e_alu = 1;
            e_fun = RX_Data[3:0];
            fr.delete();
          end
        endcase
      end
    end
    e_busy = (fr.size() != 0);
  end

  always @(negedge CLK) begin
    chk("m_wren", RF_WrEn, e_wr);
    chk("m_rden", RF_RdEn, e_rd);
    chk("m_aluen", ALU_EN, e_alu);
    chk("m_cmderr", Cmd_Err, e_cerr);
    chk("m_addrerr", Addr_Err, e_aerr);
    chk("m_busy", Busy, e_busy);
    chk("m_addr", RF_Addr, e_addr);
    chk("m_wdata", RF_WrData, e_wd);
    chk("m_fun", ALU_FUN, e_fun);
    chk("m_onehot",
        $countones({RF_WrEn, RF_RdEn, ALU_EN, Cmd_Err, Addr_Err}) <= 1, 1);
  end

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    RX_Valid = 1'b1;
    RX_Data  = b;
    @(negedge CLK);
    RX_Valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  int r;

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_busy", Busy, 0);
    chk("rst_addr", RF_Addr, 0);
    chk("rst_wren", RF_WrEn, 0);
    RST = 1'b0;

    send(8'hAA); send(8'h05); send(8'h3C);
    chk("wr_en", RF_WrEn, 1);
    chk("wr_addr", RF_Addr, 5);
    chk("wr_data", RF_WrData, 8'h3C);
    chk("wr_busy", Busy, 0);
    idle(1);
    chk("wr_en_once", RF_WrEn, 0);

    send(8'hBB); send(8'h0A);
    chk("rd_en", RF_RdEn, 1);
    chk("rd_addr", RF_Addr, 4'hA);
    chk("rd_nowr", RF_WrEn, 0);

    @(negedge CLK); RX_Valid = 1; RX_Data = 8'hCC;
    @(negedge CLK); RX_Data = 8'h12;
    chk("alu_busy", Busy, 1);
    @(negedge CLK); RX_Data = 8'h34;
    chk("a_wr", RF_WrEn, 1);
    chk("a_addr", RF_Addr, 0);
    chk("a_data", RF_WrData, 8'h12);
    @(negedge CLK); RX_Data = 8'hF3;
    chk("b_wr", RF_WrEn, 1);
    chk("b_addr", RF_Addr, 1);
    chk("b_data", RF_WrData, 8'h34);
    @(negedge CLK); RX_Valid = 0;
    chk("op_en", ALU_EN, 1);
    chk("op_fun", ALU_FUN, 3);
    chk("op_busy", Busy, 0);

    send(8'h7E);
    chk("cmd_err", Cmd_Err, 1);
    chk("cmd_busy", Busy, 0);
    send(8'hDD); send(8'h01);
    chk("dd_en", ALU_EN, 1);
    chk("dd_fun", ALU_FUN, 1);

    send(8'hAA); send(8'h1F);
    chk("aerr", Addr_Err, 1);
    chk("aerr_nowr", RF_WrEn, 0);
    chk("aerr_busy", Busy, 0);
    send(8'hBB); send(8'h02);
    chk("aerr_rd", RF_RdEn, 1);
    chk("aerr_rdaddr", RF_Addr, 2);

    send(8'hAA); idle(5); send(8'h07); idle(3); send(8'h99);
    chk("gap_wr", RF_WrEn, 1);
    chk("gap_addr", RF_Addr, 7);
    chk("gap_data", RF_WrData, 8'h99);

    send(8'hAA); send(8'h03);
    @(negedge CLK); RST = 1; RX_Valid = 1; RX_Data = 8'h55;
    @(negedge CLK); RST = 0; RX_Valid = 0;
    chk("rr_busy", Busy, 0);
    chk("rr_addr", RF_Addr, 0);
    chk("rr_data", RF_WrData, 0);
    send(8'h44);
    chk("rr_cerr", Cmd_Err, 1);
    chk("rr_nowr", RF_WrEn, 0);

    repeat (4000) begin
      @(negedge CLK);
      RST = ($urandom_range(99) == 0);
      RX_Valid = ($urandom_range(99) < 60);
      r = $urandom_range(9);
      case (r)
        0: RX_Data = 8'hAA;
        1: RX_Data = 8'hBB;
        2: RX_Data = 8'hCC;
        3: RX_Data = 8'hDD;
        4, 5: RX_Data = 8'($urandom_range(15));
        default: RX_Data = 8'($urandom_range(255));
      endcase
    end
    @(negedge CLK);
    RST = 0;
    RX_Valid = 0;
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
